// File: rtl/trig_phase_align.sv
// Trigger phase aligner: calibrates each channel's sync-pulse phase bin against a free-running
// counter, then re-times, stretches and histograms run-mode triggers per channel.
module trig_phase_align #(
  parameter int NCH        = 16,
  parameter int NBINS      = 4,
  parameter int CW         = 6,
  parameter int LOCK_COUNT = 54,
  parameter int STRETCH    = 12,
  localparam int BW        = $clog2(NBINS),
  localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_adc,
  input  logic              rst,
  input  logic [NCH-1:0]    trig_in,
  input  logic              cal_start,
  input  logic [15:0]       cal_len,
  input  logic              hist_clr,
  input  logic [CHW-1:0]    rd_ch,
  input  logic [BW:0]       rd_sel,
  output logic [31:0]       rd_data,
  output logic [NCH-1:0]    trig_out,
  output logic [NCH-1:0]    locked,
  output logic [NCH*BW-1:0] phase,
  output logic [BW-1:0]     phase_cnt,
  output logic              cal_busy,
  output logic              cal_done
);

  typedef enum logic [1:0] {ST_RUN, ST_CAL, ST_EVAL} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           cal_go;
  logic [NCH-1:0] s;
  logic [BW-1:0]  pc;
  logic [15:0]    wc;
  logic [CW-1:0]  cc [NBINS][NCH];
  logic [31:0]    rh [NBINS][NCH];
  logic [7:0]     st [NCH];
  logic [7:0]     st_nxt [NCH];
  logic [BW-1:0]  ph [NCH];
  logic [BW-1:0]  ph_eval [NCH];
  logic [BW-1:0]  rbin [NCH];
  logic [NCH-1:0] lock_eval;
  logic [31:0]    rd_nxt;
  logic [31:0]    rd_ch_ext;

  always_comb begin
    state_nxt = state;
    cal_go    = 1'b0;
    case (state)
      ST_RUN: begin
        if (cal_start) begin
          state_nxt = ST_CAL;
          cal_go    = 1'b1;
        end
      end
      ST_CAL:  if (wc <= 16'd1) state_nxt = ST_EVAL;
      ST_EVAL: state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      pc <= '0;
      s  <= '0;
      wc <= '0;
    end else begin
      pc <= pc + BW'(1);
      s  <= trig_in;
      if (cal_go)               wc <= (cal_len == 16'd0) ? 16'd1 : cal_len;
      else if (state == ST_CAL) wc <= wc - 16'd1;
    end
  end

  // Calibration counters saturate so a long window cannot alias a full bin back to zero.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBINS; b++)
        for (int j = 0; j < NCH; j++) cc[b][j] <= '0;
    end else if (cal_go) begin
      for (int b = 0; b < NBINS; b++)
        for (int j = 0; j < NCH; j++) cc[b][j] <= '0;
    end else if (state == ST_CAL) begin
      for (int j = 0; j < NCH; j++)
        if (s[j] && (cc[pc][j] != {CW{1'b1}})) cc[pc][j] <= cc[pc][j] + CW'(1);
    end
  end

  always_comb begin
    int            n_hit;
    int            n_nz;
    logic [BW-1:0] b_hit;
    n_hit     = 0;
    n_nz      = 0;
    b_hit     = '0;
    lock_eval = '0;
    for (int j = 0; j < NCH; j++) begin
      n_hit = 0;
      n_nz  = 0;
      b_hit = '0;
      for (int b = 0; b < NBINS; b++) begin
        if (cc[b][j] >= CW'(LOCK_COUNT)) begin
          n_hit = n_hit + 1;
          b_hit = BW'(b);
        end
        if (cc[b][j] != '0) n_nz = n_nz + 1;
      end
      lock_eval[j] = (n_hit == 1) && (n_nz == 1);
      ph_eval[j]   = lock_eval[j] ? b_hit : '0;
    end
  end

  always_comb begin
    for (int j = 0; j < NCH; j++) begin
      st_nxt[j] = '0;
      rbin[j]   = pc - ph[j];
    end
    if ((state == ST_RUN) && !cal_go) begin
      for (int j = 0; j < NCH; j++) begin
        if (locked[j] && s[j])  st_nxt[j] = 8'(STRETCH);
        else if (st[j] != '0)   st_nxt[j] = st[j] - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      trig_out <= '0;
      for (int j = 0; j < NCH; j++) st[j] <= '0;
    end else begin
      for (int j = 0; j < NCH; j++) begin
        st[j]       <= st_nxt[j];
        trig_out[j] <= (st_nxt[j] != '0);
      end
    end
  end

  // Run histograms are indexed relative to the locked bin, so an aligned trigger lands in bin 0.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBINS; b++)
        for (int j = 0; j < NCH; j++) rh[b][j] <= '0;
    end else if (hist_clr) begin
      for (int b = 0; b < NBINS; b++)
        for (int j = 0; j < NCH; j++) rh[b][j] <= '0;
    end else if (state == ST_RUN) begin
      for (int j = 0; j < NCH; j++)
        if (locked[j] && s[j]) rh[rbin[j]][j] <= rh[rbin[j]][j] + 32'd1;
    end
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      locked   <= '0;
      cal_done <= 1'b0;
      for (int j = 0; j < NCH; j++) ph[j] <= '0;
    end else begin
      cal_done <= (state == ST_EVAL);
      if (state == ST_EVAL) begin
        locked <= lock_eval;
        for (int j = 0; j < NCH; j++) ph[j] <= ph_eval[j];
      end
    end
  end

  assign rd_ch_ext = 32'(rd_ch);

  always_comb begin
    rd_nxt = '0;
    if (rd_ch_ext < 32'(NCH)) begin
      if (!rd_sel[BW]) rd_nxt = 32'(cc[rd_sel[BW-1:0]][rd_ch]);
      else             rd_nxt = rh[rd_sel[BW-1:0]][rd_ch];
    end
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_nxt;
  end

  always_comb begin
    phase = '0;
    for (int j = 0; j < NCH; j++) phase[j*BW +: BW] = ph[j];
  end

  assign phase_cnt = pc;
  assign cal_busy  = (state != ST_RUN);

endmodule

// File: doc/trig_phase_align.md
# trig_phase_align

Parametrised trigger phase-alignment block for the trigger distribution board. In the `clk_adc` domain it calibrates, per input channel, the phase bin in which that channel's sync pulses arrive relative to a free-running phase counter. In run mode it re-times incoming triggers into that bin, stretches them onto `trig_out`, and keeps per-bin trigger histograms for readout over the monitoring path. It generalises the fixed 16-channel, 4-bin scheme with:

- configurable channel count, bin count, lock threshold and stretch length;
- an explicit calibration handshake;
- per-channel lock status.

## Interface

Parameters:
- `NCH`, 16, number of coax channels.
- `NBINS`, 4, phase bins. Must be a power of 2, ≥2. `BW = log2(NBINS)`.
- `CW`, 6, calibration counter width. Counters saturate at 2^CW−1.
- `LOCK_COUNT`, 54, minimum hits in a single bin to declare lock. Must be ≤ 2^CW−1.
- `STRETCH`, 12, `trig_out` high time in `clk_adc` cycles per trigger. Must be ≥1, <256.

Ports (one clock; reset is asynchronous and active-high):
- `clk_adc`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `trig_in`  in  NCH  raw coax trigger inputs.
- `cal_start`  in  1  single-cycle pulse that starts a calibration.
- `cal_len`  in  16  calibration window length in cycles. Sampled on `cal_start`.
- `hist_clr`  in  1  clears the run histograms.
- `rd_ch`  in  log2(NCH)  readout channel select.
- `rd_sel`  in  BW+1  readout select: 0..NBINS−1 = calibration counts; NBINS..2·NBINS−1 = run histograms.
- `rd_data`  out  32  registered readout data.
- `trig_out`  out  NCH  aligned, stretched triggers.
- `locked`  out  NCH  per-channel lock flag.
- `phase`  out  NCH·BW  per-channel locked bin. Channel j occupies bits [j·BW +: BW].
- `phase_cnt`  out  BW  free-running phase counter `pc`.
- `cal_busy`  out  1  high in CAL and EVAL.
- `cal_done`  out  1  one-cycle pulse when calibration results become valid.

## Operation

- Input stage: `s = trig_in` registered once.
- Phase counter: `pc` increments every cycle and wraps NBINS−1→0. It is never stalled.
- FSM states: RUN (reset state), CAL, EVAL.
  - RUN→CAL on `cal_start`. On that edge: latch `cal_len` into the window counter `wc`, clear all `cc[b][j]`, clear all stretch counters.
  - CAL: for every j, if `s[j]`, then `cc[pc][j]` increments, saturating at 2^CW−1. `wc` decrements. CAL→EVAL in the cycle after the one where `wc==1`. If `cal_len==0`, it is treated as 1.
  - EVAL (1 cycle): for each j, `locked[j]` is set iff exactly one bin b has `cc[b][j] ≥ LOCK_COUNT` and every other bin of channel j is 0. In that case `phase[j] = b`; otherwise `locked[j] = 0` and `phase[j] = 0`. Next state is RUN.
  - `cal_start` is ignored in CAL and EVAL.
- RUN, per channel j:
  - If `locked[j]` and `s[j]`: bin = (pc − `phase[j]`) mod NBINS, using BW-bit wrap. Increment `rh[bin][j]` (32-bit, wraps). Load stretch counter `st[j] = STRETCH`.
  - Otherwise, if `st[j] > 0`, decrement it.
  - `trig_out[j]` is registered as `(st_next[j] != 0)`.
  - An unlocked channel never drives `trig_out` and never counts.
  - A retrigger while stretching reloads `st[j]`; there is no pulse merging beyond that.
- `hist_clr`: zeroes all `rh` in any state. In the same cycle it takes priority over an increment.
- CAL/EVAL: `trig_out` is forced 0 and `rh` is frozen except for `hist_clr`.
- Readout: `rd_data` is the zero-extended `cc[rd_sel][rd_ch]` or `rh[rd_sel−NBINS][rd_ch]`, registered. Out-of-range `rd_ch` returns 0.

## Timing

- Reset values: all outputs are 0. `pc = 0`, state RUN, all `cc`, `rh`, `st` and `wc` are 0.
- `rst` mid-CAL or mid-EVAL aborts the calibration. No `cal_done` is issued and `locked` stays 0.
- `trig_in` → `trig_out` rise: 2 cycles (input register plus output register). `trig_out` stays high for exactly STRETCH cycles after a single trigger.
- `cal_start` at cycle t: `cal_busy` high from t+1. CAL spans t+1..t+`cal_len`. EVAL is at t+`cal_len`+1. `locked`, `phase` and `cal_done` are valid at t+`cal_len`+2, with `cal_busy` low in that cycle.
- `rd_data` latency: 1 cycle from `rd_ch`/`rd_sel`.
- `s` sampled at `pc = k` lands in calibration bin k. `trig_in` high when `phase_cnt = k−1` therefore gives bin k.

## Test plan

- Reset: assert `rst` asynchronously mid-cycle. All outputs go to 0 immediately, and `phase_cnt` counts 0,1,2,3,0 after release.
- Lock: NBINS=4. `trig_in[3]` pulses every cycle with `phase_cnt == 1`, `cal_start` with `cal_len = 256`. Expected:
  - `cal_done` at t+258;
  - `locked[3] = 1`, `phase[3] = 2`;
  - `rd_sel = 2`, `rd_ch = 3` → 63 (saturated);
  - all other channels unlocked.
- Ambiguous: channel 5 pulses in both bins 1 and 2 during calibration → `locked[5] = 0`, `phase[5] = 0`. Channel 6 gets 40 hits (< `LOCK_COUNT`) → unlocked.
- Run: after the lock test, a single `trig_in[3]` pulse at `phase_cnt = 1` → `trig_out[3]` high for 12 cycles starting 2 cycles later, and `rd_sel = 4` (rh bin 0) reads 1. A retrigger after 5 cycles extends the pulse to 17 cycles total.
- `hist_clr` coincident with a counted trigger → the count reads 0. `cal_start` during CAL is ignored and `cal_done` timing is unchanged.
- `rst` at mid-CAL, cycle t+100 → no `cal_done`, `locked` is all 0, and a fresh `cal_start` afterwards completes normally.
